// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8-bit UART receiver with 16x oversampling.
// A clock-enable tick is derived from clk for the selected baud rate, so no
// derived clocks are used. Each bit is sampled once, at its centre.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   bd_rate      baud select 00=1200, 01=2400, 10=4800, 11=9600
//   parity_en    frame carries a parity bit after D7
//   parity_odd   0 = even parity, 1 = odd parity
//   rx           serial line, asynchronous, idle high
//   data_out     last received byte, held until the next completed frame
//   data_valid   one-cycle pulse, good frame
//   frame_error  one-cycle pulse, stop bit sampled 0
//   parity_error one-cycle pulse alongside data_valid/frame_error on mismatch
//   busy         receiver is not idle
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bd_rate,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       parity_error,
    output logic       busy
);

    localparam int DIV_1200 = CLK_FREQ / (1200 * OVERSAMPLE);
    localparam int DIV_2400 = CLK_FREQ / (2400 * OVERSAMPLE);
    localparam int DIV_4800 = CLK_FREQ / (4800 * OVERSAMPLE);
    localparam int DIV_9600 = CLK_FREQ / (9600 * OVERSAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_nxt;
    logic        rx_p0, rx_p1;
    logic        rx_s;
    logic [11:0] tick_cnt;
    logic [3:0]  smp_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [1:0]  bd_lat;
    logic        pen_lat, podd_lat;
    logic        perr;
    logic        armed;
    logic        tick;
    logic        start_det;

    // Reload value of the tick counter (divisor minus one) for a baud code.
    function automatic logic [11:0] div_m1(input logic [1:0] sel);
        case (sel)
            2'b00:   return 12'(DIV_1200 - 1);
            2'b01:   return 12'(DIV_2400 - 1);
            2'b10:   return 12'(DIV_4800 - 1);
            default: return 12'(DIV_9600 - 1);
        endcase
    endfunction

    assign rx_s = rx_p1;
    assign tick = (state != IDLE) && (tick_cnt == 12'd0);
    // armed is cleared by a stop bit sampled low, so a held-low line (break)
    // cannot retrigger until it has been seen high again.
    assign start_det = (state == IDLE) && !rx_s && armed;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_det) state_nxt = START;
            START:  if (tick && smp_cnt == 4'd7) state_nxt = rx_s ? IDLE : DATA;
            DATA:   if (tick && smp_cnt == 4'd15 && bit_cnt == 3'd7)
                        state_nxt = pen_lat ? PARITY : STOP;
            PARITY: if (tick && smp_cnt == 4'd15) state_nxt = STOP;
            // Leave at mid-stop-bit so a back-to-back start edge is caught.
            STOP:   if (tick && smp_cnt == 4'd15) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0/p1: two-flop synchronizer for rx; control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0        <= 1'b1;
            rx_p1        <= 1'b1;
            tick_cnt     <= 12'd0;
            smp_cnt      <= 4'd0;
            bit_cnt      <= 3'd0;
            bd_lat       <= 2'b00;
            pen_lat      <= 1'b0;
            podd_lat     <= 1'b0;
            perr         <= 1'b0;
            armed        <= 1'b1;
            data_out     <= 8'h00;
            data_valid   <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            rx_p0        <= rx;
            rx_p1        <= rx_p0;
            data_valid   <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            if (state == IDLE && rx_s) armed <= 1'b1;
            if (start_det) begin
                bd_lat   <= bd_rate;
                pen_lat  <= parity_en;
                podd_lat <= parity_odd;
                tick_cnt <= div_m1(bd_rate);
                smp_cnt  <= 4'd0;
                bit_cnt  <= 3'd0;
                perr     <= 1'b0;
            end else if (state != IDLE) begin
                tick_cnt <= (tick_cnt == 12'd0) ? div_m1(bd_lat) : tick_cnt - 12'd1;
                if (tick) begin
                    if (state == START && smp_cnt == 4'd7) smp_cnt <= 4'd0;
                    else                                     smp_cnt <= smp_cnt + 4'd1;
                    if (smp_cnt == 4'd15) begin
                        case (state)
                            DATA:   bit_cnt <= bit_cnt + 3'd1;
                            PARITY: perr <= (rx_s != (^shift_reg ^ podd_lat));
                            STOP: begin
                                data_out     <= shift_reg;
                                data_valid   <= rx_s;
                                frame_error  <= !rx_s;
                                parity_error <= perr;
                                armed        <= rx_s;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Data shift register, LSB first; no reset needed since every frame
    // overwrites all eight bits before data_out is loaded.
    always_ff @(posedge clk) begin
        if (state == DATA && tick && smp_cnt == 4'd15)
            shift_reg <= {rx_s, shift_reg[7:1]};
    end

endmodule
